// File: rtl/cmp_arbiter_if.sv
// Requester, response and compare-unit signals of cmp_arbiter.
// master: requesters plus compare unit; slave: the arbiter.
interface cmp_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             REQ0_VALID;
  logic [WIDTH-1:0] REQ0_A;
  logic [WIDTH-1:0] REQ0_B;
  logic [1:0]       REQ0_FUN;
  logic             REQ0_READY;
  logic             REQ1_VALID;
  logic [WIDTH-1:0] REQ1_A;
  logic [WIDTH-1:0] REQ1_B;
  logic [1:0]       REQ1_FUN;
  logic             REQ1_READY;
  logic             RSP0_VALID;
  logic             RSP1_VALID;
  logic [WIDTH-1:0] RSP_DATA;
  logic             RSP_ERR;
  logic             BUSY;
  logic [WIDTH-1:0] CMP_A;
  logic [WIDTH-1:0] CMP_B;
  logic [1:0]       CMP_FUN;
  logic             CMP_Enable;
  logic [WIDTH-1:0] CMP_OUT;
  logic             CMP_Flag;

  modport master (
    output REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    output REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    output CMP_OUT, CMP_Flag,
    input  REQ0_READY, REQ1_READY,
    input  RSP0_VALID, RSP1_VALID, RSP_DATA, RSP_ERR,
    input  BUSY, CMP_A, CMP_B, CMP_FUN, CMP_Enable
  );

  modport slave (
    input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_FUN,
    input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_FUN,
    input  CMP_OUT, CMP_Flag,
    output REQ0_READY, REQ1_READY,
    output RSP0_VALID, RSP1_VALID, RSP_DATA, RSP_ERR,
    output BUSY, CMP_A, CMP_B, CMP_FUN, CMP_Enable
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin sharing of one registered compare unit between two
// requesters, with a watchdog that answers with an error on timeout.
module cmp_arbiter #(
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_CYC = 8
) (
  input logic          CLK,
  input logic          RST,
  cmp_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  localparam int CW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic             ptr;
  logic             owner;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       fun_q;
  logic [WIDTH-1:0] data_q;
  logic             err_q;
  logic             rsp0_q;
  logic             rsp1_q;

  logic v0;
  logic v1;
  logic gnt_any;
  logic gnt_id;

  assign v0 = bus.REQ0_VALID;
  assign v1 = bus.REQ1_VALID;

  // ptr names the winner of a tie
  always_comb begin
    gnt_any = v0 | v1;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (v0 & v1):  gnt_id = ptr;
      (v0 & ~v1): gnt_id = 1'b0;
      default:    gnt_id = 1'b1;
    endcase
  end

  assign bus.REQ0_READY =
    (state == IDLE) & gnt_any & ~gnt_id;
  assign bus.REQ1_READY =
    (state == IDLE) & gnt_any & gnt_id;

  assign bus.BUSY       = (state != IDLE);
  assign bus.CMP_Enable = (state == ISSUE);
  assign bus.CMP_A      = a_q;
  assign bus.CMP_B      = b_q;
  assign bus.CMP_FUN    = fun_q;
  assign bus.RSP_DATA   = data_q;
  assign bus.RSP_ERR    = err_q;
  assign bus.RSP0_VALID = rsp0_q;
  assign bus.RSP1_VALID = rsp1_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      owner  <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      fun_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            a_q   <= gnt_id ? bus.REQ1_A : bus.REQ0_A;
            b_q   <= gnt_id ? bus.REQ1_B : bus.REQ0_B;
            fun_q <= gnt_id ? bus.REQ1_FUN
                            : bus.REQ0_FUN;
            owner <= gnt_id;
            if (v0 & v1)
              ptr <= ~gnt_id;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.CMP_Flag) begin
            data_q <= bus.CMP_OUT;
            err_q  <= 1'b0;
            rsp0_q <= ~owner;
            rsp1_q <= owner;
            state  <= IDLE;
          end else if (cnt == CNT_MAX) begin
            data_q <= '0;
            err_q  <= 1'b1;
            rsp0_q <= ~owner;
            rsp1_q <= owner;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
